// File: rtl/tanh_stream_ctrl.sv
// Valid/ready stream wrapper around the fixed-latency tanh_FPsingle core, with credit-based
// output FIFO. Optional macro TANH_NAN_PASS_EN replaces NaN results by the canonical quiet NaN.
module tanh_stream_ctrl #(
    parameter int CORE_LAT   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic [31:0] core_in,
    output logic        core_enable,
    input  logic [31:0] core_out,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic                en;
    logic [CORE_LAT-1:0] vld;
    logic [CW-1:0]       occ;
    logic [CW-1:0]       fifo_count;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [31:0]         mem [FIFO_DEPTH];
    logic                accept;
    logic                push;
    logic                pop;
    logic [31:0]         push_data;

    assign s_ready     = en && (occ < DEPTH_C);
    assign accept      = s_valid && s_ready;
    assign core_in     = accept ? s_data : '0;
    assign core_enable = en;
    assign push        = vld[CORE_LAT-1];
    assign m_valid     = (fifo_count != '0);
    assign pop         = m_valid && m_ready;
    assign m_data      = m_valid ? mem[rd_ptr] : '0;
    assign busy        = (occ != '0);

`ifdef TANH_NAN_PASS_EN
    logic [CORE_LAT-1:0] nan_line;
    logic                s_is_nan;

    assign s_is_nan  = (s_data[30:23] == 8'hFF) && (s_data[22:0] != '0);
    assign push_data = nan_line[CORE_LAT-1] ? 32'h7FC0_0000 : core_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_line <= '0;
        end else begin
            nan_line[0] <= accept && s_is_nan;
            for (int unsigned i = 1; i < CORE_LAT; i++) nan_line[i] <= nan_line[i-1];
        end
    end
`else
    assign push_data = core_out;
`endif

    // vld mirrors the core pipeline: the core itself never stalls and has no reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en  <= 1'b0;
            vld <= '0;
        end else begin
            en     <= 1'b1;
            vld[0] <= accept;
            for (int unsigned i = 1; i < CORE_LAT; i++) vld[i] <= vld[i-1];
        end
    end

    // occ counts every sample from accept to pop, so a push always finds room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_tanh_stream_ctrl.sv
// Self-checking bench for tanh_stream_ctrl: behavioural core model plus a queue-based
// reference of accepted samples, their expected results and the cycle they become visible.
module tb_tanh_stream_ctrl;

    localparam int CORE_LAT   = 4;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [31:0] core_in;
    logic        core_enable;
    logic [31:0] core_out;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        busy;

    tanh_stream_ctrl #(.CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_in(core_in), .core_enable(core_enable), .core_out(core_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the tanh LUT core: saturates large magnitudes, quiets NaNs, scrambles the rest
    function automatic logic [31:0] core_fn(input logic [31:0] x);
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return x | 32'h0040_0000;
        if (x[30:23] >= 8'd130) return x[31] ? 32'hBF80_0000 : 32'h3F80_0000;
        return x ^ 32'h0055_AA00;
    endfunction

    function automatic logic [31:0] expected_out(input logic [31:0] x);
`ifdef TANH_NAN_PASS_EN
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h7FC0_0000;
`endif
        return core_fn(x);
    endfunction

    logic [31:0] pipe [CORE_LAT];
    always @(posedge clk) begin
        pipe[0] <= core_fn(core_in);
        for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[CORE_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          avail;
    } item_t;
    item_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic        o_sready, o_mvalid, o_busy, acc, popd;
    logic [31:0] o_mdata, o_corein;
    int          s_cyc;

    task automatic drive_sample(input logic sv, input logic [31:0] sd, input logic mr);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        o_sready = s_ready;
        o_mvalid = m_valid;
        o_mdata  = m_data;
        o_busy   = busy;
        o_corein = core_in;
        acc      = sv && s_ready;
        popd     = m_valid && mr;
        s_cyc    = cyc;
    endtask

    // Result becomes visible CORE_LAT edges after the accept edge, i.e. observation cycle +CORE_LAT+1
    task automatic model_step(input logic [31:0] sd);
        item_t it;
        if (popd && q.size() != 0) void'(q.pop_front());
        if (acc) begin
            it.data  = expected_out(sd);
            it.avail = s_cyc + CORE_LAT + 1;
            q.push_back(it);
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        s_data  = 32'h4120_0000;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || core_enable !== 1'b0 ||
                core_in !== 32'h0 || m_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold: sready=%b mvalid=%b busy=%b en=%b core_in=%h m_data=%h, want all 0",
                         s_ready, m_valid, busy, core_enable, core_in, m_data);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (core_enable !== 1'b1 || s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: en=%b sready=%b mvalid=%b busy=%b, want 1 1 0 0",
                     core_enable, s_ready, m_valid, busy);
        end
        s_valid = 1'b0;
        q.delete();
    endtask

    task automatic test_latency(input logic [31:0] sd, input logic [31:0] want);
        int acc_cyc;
        int rise;
        drive_sample(1'b1, sd, 1'b1);
        acc_cyc = s_cyc;
        n_tests++;
        if (acc !== 1'b1 || o_corein !== sd) begin
            n_fail++;
            $display("FAIL latency_accept: acc=%b core_in=%h, want 1 %h", acc, o_corein, sd);
        end
        model_step(sd);
        rise = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            drive_sample(1'b0, 32'h0, 1'b1);
            if (o_mvalid) begin
                rise = s_cyc;
                n_tests++;
                if (o_mdata !== want) begin
                    n_fail++;
                    $display("FAIL latency_data: m_data=%h want %h", o_mdata, want);
                end
            end
            model_step(32'h0);
        end
        n_tests++;
        if (rise - acc_cyc != CORE_LAT + 1) begin
            n_fail++;
            $display("FAIL latency_edges: m_valid after %0d edges, want %0d", rise - acc_cyc - 1, CORE_LAT);
        end
        drive_sample(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (o_mvalid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_idle: mvalid=%b busy=%b, want 0 0", o_mvalid, o_busy);
        end
        model_step(32'h0);
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        int n_pop = 0;
        logic [31:0] sd;
        for (int i = 0; i < 20; i++) begin
            sd = $urandom;
            drive_sample(1'b1, sd, 1'b0);
            if (acc) n_acc++;
            model_step(sd);
        end
        drive_sample(1'b0, 32'h0, 1'b0);
        n_tests++;
        if (n_acc != FIFO_DEPTH || o_sready !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_fill: accepted=%0d sready=%b busy=%b, want %0d 0 1", n_acc, o_sready, o_busy, FIFO_DEPTH);
        end
        model_step(32'h0);
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            drive_sample(1'b0, 32'h0, 1'b1);
            if (popd) begin
                n_pop++;
                n_tests++;
                if (o_mdata !== q[0].data) begin
                    n_fail++;
                    $display("FAIL bp_order: m_data=%h want %h", o_mdata, q[0].data);
                end
            end
            model_step(32'h0);
        end
        drive_sample(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (n_pop != FIFO_DEPTH || o_sready !== 1'b1 || o_mvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: pops=%0d sready=%b mvalid=%b, want %0d 1 0", n_pop, o_sready, o_mvalid, FIFO_DEPTH);
        end
        model_step(32'h0);
    endtask

    task automatic test_streaming();
        int n_acc = 0;
        int guard = 0;
        logic sv, mr, exp_mv;
        logic [31:0] sd;
        while ((n_acc < 100 || q.size() != 0) && guard < 3000) begin
            guard++;
            sv = (n_acc < 100) && ($urandom_range(0, 2) != 0);
            mr = (n_acc >= 100) || ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       sd = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
                1:       sd = {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
                default: sd = $urandom;
            endcase
            drive_sample(sv, sd, mr);
            exp_mv = (q.size() != 0) && (s_cyc >= q[0].avail);
            n_tests++;
            if (o_mvalid !== exp_mv || (exp_mv && o_mdata !== q[0].data)) begin
                n_fail++;
                $display("FAIL stream_out: cyc=%0d mvalid=%b data=%h, want %b %h",
                         s_cyc, o_mvalid, o_mdata, exp_mv, exp_mv ? q[0].data : 32'h0);
            end
            n_tests++;
            if (o_sready !== (q.size() < FIFO_DEPTH) || o_busy !== (q.size() != 0) ||
                o_corein !== (acc ? sd : 32'h0) || q.size() > FIFO_DEPTH) begin
                n_fail++;
                $display("FAIL stream_flow: cyc=%0d sready=%b busy=%b core_in=%h, occ=%0d",
                         s_cyc, o_sready, o_busy, o_corein, q.size());
            end
            if (acc) n_acc++;
            model_step(sd);
        end
        n_tests++;
        if (guard >= 3000) begin
            n_fail++;
            $display("FAIL stream_timeout: accepted=%0d remaining=%0d", n_acc, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] sd;
        int n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            sd = $urandom;
            drive_sample(1'b1, sd, 1'b0);
            if (acc) n_acc++;
            model_step(sd);
        end
        repeat (CORE_LAT + 1) begin
            drive_sample(1'b0, 32'h0, 1'b0);
            model_step(32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            sd = $urandom;
            drive_sample(1'b1, sd, 1'b0);
            if (acc) n_acc++;
            model_step(sd);
        end
        @(negedge clk);
        s_valid = 1'b0;
        n_tests++;
        if (n_acc != 8 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: accepted=%0d mvalid=%b, want 8 1", n_acc, m_valid);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: mvalid=%b busy=%b sready=%b, want 0 0 0", m_valid, busy, s_ready);
        end
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < CORE_LAT + 4; i++) begin
            drive_sample(1'b0, 32'h0, 1'b1);
            n_tests++;
            if (o_mvalid !== 1'b0 || o_busy !== 1'b0 || o_sready !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_stale: i=%0d mvalid=%b busy=%b sready=%b, want 0 0 1",
                         i, o_mvalid, o_busy, o_sready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency(32'h4120_0000, 32'h3F80_0000);
        test_latency(32'hC120_0000, 32'hBF80_0000);
`ifdef TANH_NAN_PASS_EN
        test_latency(32'h7FA0_0001, 32'h7FC0_0000);
`else
        test_latency(32'h7FA0_0001, 32'h7FE0_0001);
`endif
        test_latency(32'h7F80_0000, 32'h3F80_0000);
        test_latency(32'hFF80_0000, 32'hBF80_0000);
        test_backpressure();
        test_streaming();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
